// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - raster timing generator; VGA_TIMING_TEST_PATTERN_EN adds the o_rgb colour-bar output
module vga_timing_gen #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int SYNC_POL = 0
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_en,
    output logic       o_hsync,
    output logic       o_vsync,
    output logic       o_active,
    output logic [9:0] o_x,
    output logic [9:0] o_y,
    output logic       o_line_start,
    output logic       o_frame_start
`ifdef VGA_TIMING_TEST_PATTERN_EN
    ,
    output logic [11:0] o_rgb
`endif
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS    = 10'(H_ACTIVE);
    localparam logic [9:0] V_VIS    = 10'(V_ACTIVE);
    localparam logic [9:0] HS_BEGIN = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] HS_END   = 10'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0] VS_BEGIN = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC);

    // Asserted sync level; the idle level is its complement.
    localparam logic SYNC_ON = (SYNC_POL != 0);

    logic [9:0] h_cnt;
    logic [9:0] v_cnt;

    logic active_d;
    logic hsync_d;
    logic vsync_d;
    logic line_start_d;
    logic frame_start_d;

    // Raster position: h advances per enabled pixel, v advances on the h wrap.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (i_en) begin
            if (h_cnt == H_LAST) begin
                h_cnt <= '0;
                if (v_cnt == V_LAST) begin
                    v_cnt <= '0;
                end else begin
                    v_cnt <= v_cnt + 10'd1;
                end
            end else begin
                h_cnt <= h_cnt + 10'd1;
            end
        end
    end

    // Decode of the current raster position; pulses qualify on i_en so a held
    // position under a sparse enable does not stretch them.
    always_comb begin
        active_d      = (h_cnt < H_VIS) && (v_cnt < V_VIS);
        hsync_d       = ((h_cnt >= HS_BEGIN) && (h_cnt < HS_END)) ? SYNC_ON : ~SYNC_ON;
        vsync_d       = ((v_cnt >= VS_BEGIN) && (v_cnt < VS_END)) ? SYNC_ON : ~SYNC_ON;
        line_start_d  = (h_cnt == 10'd0) && i_en;
        frame_start_d = line_start_d && (v_cnt == 10'd0);
    end

    // Output stage samples the decode every clock so all outputs share one cycle of latency.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_x           <= '0;
            o_y           <= '0;
            o_active      <= 1'b0;
            o_hsync       <= ~SYNC_ON;
            o_vsync       <= ~SYNC_ON;
            o_line_start  <= 1'b0;
            o_frame_start <= 1'b0;
        end else begin
            o_x           <= h_cnt;
            o_y           <= v_cnt;
            o_active      <= active_d;
            o_hsync       <= hsync_d;
            o_vsync       <= vsync_d;
            o_line_start  <= line_start_d;
            o_frame_start <= frame_start_d;
        end
    end

`ifdef VGA_TIMING_TEST_PATTERN_EN
    localparam int BAR_W = H_ACTIVE / 8;

    logic [2:0]  bar;
    logic [11:0] rgb_d;

    // Bar index by threshold compare against each bar edge, avoiding a divider.
    always_comb begin
        bar = 3'd0;
        for (int k = 1; k < 8; k++) begin
            if (h_cnt >= 10'(k * BAR_W)) begin
                bar = 3'(k);
            end
        end
    end

    // Bar colour lookup, blanked outside the visible region.
    always_comb begin
        rgb_d = 12'h000;
        if (active_d) begin
            case (bar)
                3'd0:    rgb_d = 12'hFFF;
                3'd1:    rgb_d = 12'hFF0;
                3'd2:    rgb_d = 12'h0FF;
                3'd3:    rgb_d = 12'h0F0;
                3'd4:    rgb_d = 12'hF0F;
                3'd5:    rgb_d = 12'hF00;
                3'd6:    rgb_d = 12'h00F;
                default: rgb_d = 12'h000;
            endcase
        end
    end

    // Colour register kept in step with o_x/o_y.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_rgb <= 12'h000;
        end else begin
            o_rgb <= rgb_d;
        end
    end
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb/tb_vga_timing_gen.sv - scoreboard bench for vga_timing_gen (short vertical raster, default horizontal)
module tb_vga_timing_gen;

    logic       i_clk = 1'b0;
    logic       i_rst = 1'b1;
    logic       i_en  = 1'b1;
    logic       o_hsync;
    logic       o_vsync;
    logic       o_active;
    logic [9:0] o_x;
    logic [9:0] o_y;
    logic       o_line_start;
    logic       o_frame_start;
`ifdef VGA_TIMING_TEST_PATTERN_EN
    logic [11:0] o_rgb;
`endif

    // Horizontal timing is the default 800-clock line; vertical is shortened to
    // 11 lines (active 0..3, front porch 4..5, sync 6..7, back porch 8..10) so
    // that a full sparse-enable frame fits in the cycle budget.
    vga_timing_gen #(
        .V_ACTIVE(4),
        .V_FP(2),
        .V_SYNC(2),
        .V_BP(3)
    ) dut (
        .i_clk(i_clk),
        .i_rst(i_rst),
        .i_en(i_en),
        .o_hsync(o_hsync),
        .o_vsync(o_vsync),
        .o_active(o_active),
        .o_x(o_x),
        .o_y(o_y),
        .o_line_start(o_line_start),
        .o_frame_start(o_frame_start)
`ifdef VGA_TIMING_TEST_PATTERN_EN
        ,
        .o_rgb(o_rgb)
`endif
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        int         cyc;
        string      name;
        logic [9:0] x;
        logic [9:0] y;
        logic       act;
        logic       hs;
        logic       vs;
        logic       ls;
        logic       fs;
        logic [11:0] rgb;
    } exp_t;

    exp_t q[$];
    int   cyc     = 0;
    int   n_checks = 0;
    int   n_fail   = 0;

    always @(posedge i_clk) cyc <= cyc + 1;

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic push(input int c, input string nm, input int x, input int y,
                        input bit act, input bit hs, input bit vs, input bit ls,
                        input bit fs, input int rgb);
        exp_t e;
        e.cyc = c; e.name = nm; e.x = 10'(x); e.y = 10'(y);
        e.act = act; e.hs = hs; e.vs = vs; e.ls = ls; e.fs = fs; e.rgb = 12'(rgb);
        q.push_back(e);
    endtask

    // Monitor: at each falling edge, compare every expectation due this cycle.
    initial begin
        forever begin
            @(negedge i_clk);
            while (q.size() > 0 && q[0].cyc <= cyc) begin
                exp_t e;
                logic [26:0] got;
                logic [26:0] want;
                bit ok;
                e = q.pop_front();
                n_checks++;
                if (e.cyc < cyc) begin
                    n_fail++;
                    $display("FAIL %s: scheduled cycle %0d passed unchecked (now %0d)", e.name, e.cyc, cyc);
                end else begin
                    got  = {o_x, o_y, o_active, o_hsync, o_vsync, o_line_start, o_frame_start};
                    want = {e.x, e.y, e.act, e.hs, e.vs, e.ls, e.fs};
                    ok = (got === want);
`ifdef VGA_TIMING_TEST_PATTERN_EN
                    ok = ok && (o_rgb === e.rgb);
                    if (!ok) $display("FAIL %s: rgb got %h want %h", e.name, o_rgb, e.rgb);
`endif
                    if (!ok) begin
                        n_fail++;
                        $display("FAIL %s: got x=%0d y=%0d act=%b hs=%b vs=%b ls=%b fs=%b want x=%0d y=%0d act=%b hs=%b vs=%b ls=%b fs=%b",
                                 e.name, o_x, o_y, o_active, o_hsync, o_vsync, o_line_start, o_frame_start,
                                 e.x, e.y, e.act, e.hs, e.vs, e.ls, e.fs);
                    end
                end
            end
        end
    end

    // Stimulus: pushes hand-computed expectations keyed by output index n,
    // where index 0 is the first clock edge after reset release.
    initial begin
        int base;
        int base2;
        int base3;

        repeat (3) tick();
        push(cyc, "rst_init", 0, 0, 0, 1, 1, 0, 0, 'h000);
        tick();

        // Phase A: full-rate enable from reset, through one frame and into a mid-frame reset.
        i_rst = 1'b0;
        base = cyc + 1;
        push(base + 0,     "a_first",    0,   0,  1, 1, 1, 1, 1, 'hFFF);
        push(base + 1,     "a_x1",       1,   0,  1, 1, 1, 0, 0, 'hFFF);
        push(base + 80,    "a_bar1",     80,  0,  1, 1, 1, 0, 0, 'hFF0);
        push(base + 400,   "a_bar5",     400, 0,  1, 1, 1, 0, 0, 'hF00);
        push(base + 639,   "a_x639",     639, 0,  1, 1, 1, 0, 0, 'h000);
        push(base + 640,   "a_x640",     640, 0,  0, 1, 1, 0, 0, 'h000);
        push(base + 655,   "a_hs_pre",   655, 0,  0, 1, 1, 0, 0, 'h000);
        push(base + 656,   "a_hs_on",    656, 0,  0, 0, 1, 0, 0, 'h000);
        push(base + 751,   "a_hs_last",  751, 0,  0, 0, 1, 0, 0, 'h000);
        push(base + 752,   "a_hs_off",   752, 0,  0, 1, 1, 0, 0, 'h000);
        push(base + 799,   "a_x799",     799, 0,  0, 1, 1, 0, 0, 'h000);
        push(base + 800,   "a_line1",    0,   1,  1, 1, 1, 1, 0, 'hFFF);
        push(base + 801,   "a_line1_x1", 1,   1,  1, 1, 1, 0, 0, 'hFFF);
        push(base + 1600,  "a_line2",    0,   2,  1, 1, 1, 1, 0, 'hFFF);
        push(base + 2400,  "a_line3",    0,   3,  1, 1, 1, 1, 0, 'hFFF);
        push(base + 3200,  "a_line4",    0,   4,  0, 1, 1, 1, 0, 'h000);
        push(base + 4799,  "a_vs_pre",   799, 5,  0, 1, 1, 0, 0, 'h000);
        push(base + 4800,  "a_vs_on",    0,   6,  0, 1, 0, 1, 0, 'h000);
        push(base + 5456,  "a_both",     656, 6,  0, 0, 0, 0, 0, 'h000);
        push(base + 6399,  "a_vs_last",  799, 7,  0, 1, 0, 0, 0, 'h000);
        push(base + 6400,  "a_vs_off",   0,   8,  0, 1, 1, 1, 0, 'h000);
        push(base + 8799,  "a_last",     799, 10, 0, 1, 1, 0, 0, 'h000);
        push(base + 8800,  "a_wrap",     0,   0,  1, 1, 1, 1, 1, 'hFFF);
        push(base + 8801,  "a_wrap_x1",  1,   0,  1, 1, 1, 0, 0, 'hFFF);
        push(base + 15099, "a_presync",  699, 7,  0, 0, 0, 0, 0, 'h000);
        push(base + 15100, "rst_async",  0,   0,  0, 1, 1, 0, 0, 'h000);
        push(base + 15101, "rst_hold",   0,   0,  0, 1, 1, 0, 0, 'h000);

        while (cyc < base + 15100) tick();
        i_rst = 1'b1;
        tick();
        tick();

        // Restart after the mid-frame reset: full-length syncs from (0,0).
        i_rst = 1'b0;
        base2 = cyc + 1;
        push(base2 + 0,    "r_first",   0,   0, 1, 1, 1, 1, 1, 'hFFF);
        push(base2 + 655,  "r_hs_pre",  655, 0, 0, 1, 1, 0, 0, 'h000);
        push(base2 + 656,  "r_hs_on",   656, 0, 0, 0, 1, 0, 0, 'h000);
        push(base2 + 751,  "r_hs_last", 751, 0, 0, 0, 1, 0, 0, 'h000);
        push(base2 + 752,  "r_hs_off",  752, 0, 0, 1, 1, 0, 0, 'h000);
        push(base2 + 4799, "r_vs_pre",  799, 5, 0, 1, 1, 0, 0, 'h000);
        push(base2 + 4800, "r_vs_on",   0,   6, 0, 1, 0, 1, 0, 'h000);
        push(base2 + 6399, "r_vs_last", 799, 7, 0, 1, 0, 0, 0, 'h000);
        push(base2 + 6400, "r_vs_off",  0,   8, 0, 1, 1, 1, 0, 'h000);
        while (cyc < base2 + 6402) tick();

        i_rst = 1'b1;
        push(cyc, "rst_again", 0, 0, 0, 1, 1, 0, 0, 'h000);
        tick();

        // Sparse enable: i_en high for output index n when n % 4 == 0.
        i_rst = 1'b0;
        i_en  = 1'b1;
        base3 = cyc + 1;
        push(base3 + 0,     "s_first",    0,   0,  1, 1, 1, 1, 1, 'hFFF);
        push(base3 + 1,     "s_x1",       1,   0,  1, 1, 1, 0, 0, 'hFFF);
        push(base3 + 4,     "s_x1_hold",  1,   0,  1, 1, 1, 0, 0, 'hFFF);
        push(base3 + 5,     "s_x2",       2,   0,  1, 1, 1, 0, 0, 'hFFF);
        push(base3 + 3196,  "s_x799",     799, 0,  0, 1, 1, 0, 0, 'h000);
        push(base3 + 3197,  "s_l1_early", 0,   1,  1, 1, 1, 0, 0, 'hFFF);
        push(base3 + 3199,  "s_l1_wait",  0,   1,  1, 1, 1, 0, 0, 'hFFF);
        push(base3 + 3200,  "s_l1_pulse", 0,   1,  1, 1, 1, 1, 0, 'hFFF);
        push(base3 + 3201,  "s_l1_after", 1,   1,  1, 1, 1, 0, 0, 'hFFF);
        push(base3 + 6400,  "s_l2_pulse", 0,   2,  1, 1, 1, 1, 0, 'hFFF);
        push(base3 + 35196, "s_last",     799, 10, 0, 1, 1, 0, 0, 'h000);
        push(base3 + 35199, "s_f_wait",   0,   0,  1, 1, 1, 0, 0, 'hFFF);
        push(base3 + 35200, "s_f_pulse",  0,   0,  1, 1, 1, 1, 1, 'hFFF);
        push(base3 + 35201, "s_f_after",  1,   0,  1, 1, 1, 0, 0, 'hFFF);
        for (int k = 1; k <= 35204; k++) begin
            tick();
            i_en = ((k % 4) == 0);
        end

        tick();
        tick();
        while (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            n_checks++;
            n_fail++;
            $display("FAIL %s: never observed (due cycle %0d, now %0d)", e.name, e.cyc, cyc);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Raster timing generator for the display path; consumes the 25 MHz pixel clock from the clock divider, or a pixel-rate enable when run from the 100 MHz system clock.
- Produces horizontal and vertical sync, active-video flag, pixel coordinates, and line/frame start pulses for the pixel-fetch and RGB output stages.
- Default timing is 640x480 @ 60 Hz: 800 clocks per line, 525 lines per frame.

Parameters:
H_ACTIVE, 640, visible pixels per line
H_FP, 16, horizontal front porch (pixels)
H_SYNC, 96, horizontal sync width (pixels)
H_BP, 48, horizontal back porch (pixels)
V_ACTIVE, 480, visible lines per frame
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vertical sync width (lines)
V_BP, 33, vertical back porch (lines)
SYNC_POL, 0, asserted level of o_hsync/o_vsync (0 = active-low)

Ports:
i_clk  in  1  pixel clock, or system clock when i_en is strobed
i_rst  in  1  reset, asynchronous, active-high
i_en  in  1  pixel advance enable; tie high when i_clk is the pixel clock
o_hsync  out  1  horizontal sync, level per SYNC_POL
o_vsync  out  1  vertical sync, level per SYNC_POL
o_active  out  1  high while the pixel is in the visible region
o_x  out  10  horizontal position, 0..H_TOTAL-1
o_y  out  10  vertical position, 0..V_TOTAL-1
o_line_start  out  1  one-clock pulse at start of each line
o_frame_start  out  1  one-clock pulse at start of each frame

Behaviour:
- Derived totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800); V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (525). Both must be at most 1024; counters are 10 bits unsigned.
- Internal h_cnt, v_cnt advance only on i_clk edges with i_en=1. i_en=0 holds both counters.
- h_cnt wraps from H_TOTAL-1 to 0. v_cnt increments only on that wrap.
- v_cnt wraps from V_TOTAL-1 to 0 on the h wrap, so the frame boundary is the transition (799,524) -> (0,0).
- Output registers sample a decode of (h_cnt, v_cnt) on every i_clk edge, independent of i_en. Latency is 1 clock, and all outputs stay mutually aligned.
- o_x = h_cnt, o_y = v_cnt.
- o_active = (h_cnt < H_ACTIVE) and (v_cnt < V_ACTIVE).
- o_hsync is at SYNC_POL when H_ACTIVE+H_FP <= h_cnt < H_ACTIVE+H_FP+H_SYNC (656..751); otherwise ~SYNC_POL.
- o_vsync is at SYNC_POL when V_ACTIVE+V_FP <= v_cnt < V_ACTIVE+V_FP+V_SYNC (490..491), for entire lines; otherwise ~SYNC_POL.
- o_line_start = registered (h_cnt==0 and i_en). It is exactly one clock wide even when i_en is sparse.
- o_frame_start = registered (h_cnt==0 and v_cnt==0 and i_en).
- Reset (asynchronous assert): h_cnt = v_cnt = 0; o_x = o_y = 0; o_active = 0; o_line_start = o_frame_start = 0; o_hsync = o_vsync = ~SYNC_POL.
- Reset release is synchronous in effect. First clock edge after release loads the outputs with the decode of (0,0).
- Reset mid-frame: the raster restarts at (0,0) with no partial sync pulse. A sync active at reset assertion deasserts immediately.
- No other state. Timing errors and overflow are impossible by construction; out-of-range parameter sets are unsupported.

Optional Feature:
- Macro: VGA_TIMING_TEST_PATTERN_EN.
- Defined:
  - Adds port o_rgb, out, 12 bits, 4:4:4, registered and aligned with o_x/o_y.
  - Outputs 8 vertical colour bars, each H_ACTIVE/8 pixels wide. Bar index = o_x / (H_ACTIVE/8).
  - Bar colours in order: FFF, FF0, 0FF, 0F0, F0F, F00, 00F, 000.
  - o_rgb = 0 whenever o_active=0 and during reset.
- Undefined: o_rgb port and its logic are absent; all other behaviour is identical.

Test Plan:
- Reset: assert i_rst mid-count -> o_x=0, o_y=0, o_active=0, o_hsync=1, o_vsync=1, pulses 0, all without a clock edge. After release, first edge gives o_active=1 and o_frame_start=1.
- Line timing, i_en=1: o_hsync=0 exactly while o_x is 656..751. o_active=1 for o_x 0..639 on line 0. o_line_start period is 800 clocks.
- Frame timing, i_en=1: o_vsync=0 for o_y 490..491, i.e. 1600 clocks. o_frame_start pulses every 420000 clocks, and o_y wraps 524 -> 0.
- Sparse enable, i_en high 1 clock in 4: o_x holds 4 clocks per value. o_line_start is 1 clock wide every 3200 clocks. o_frame_start period is 1680000 clocks.
- Mid-frame reset at o_x=700, o_y=491, with both syncs asserted: syncs deassert immediately, and the next frame restarts from (0,0) with full-length sync pulses.
- With VGA_TIMING_TEST_PATTERN_EN: o_rgb=FFF at o_x=0, FF0 at o_x=80, 000 at o_x=639, and 000 at o_x=640 or o_y=480.
